// File: rtl/im_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The IFU and testbenches import the same defaults.
package im_loader_pkg;

  localparam logic [31:0] CODE_SEG_PC_DEFAULT = 32'h0000_3000;
  localparam int          IM_WORDS_DEFAULT    = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/im_loader_word_assembler.sv
// Big-endian byte-to-word shift-in register.
// word_valid is combinational: it rises in the same cycle the 4th byte is
// accepted, so the owner can latch the completed word on that edge.
module im_loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_fire,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  // Shift in accepted bytes; the 2-bit counter wraps 3->0 per word.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = 2'd0;
    end else if (byte_fire) begin
      shift_d = {shift_q[15:0], byte_in};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  assign word       = {shift_q, byte_in};
  assign word_valid = byte_fire && !clear && (cnt_q == 2'd3);

  // Register the partial word and byte position.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: receives a length-prefixed big-endian byte
// stream and writes it to consecutive IM words from CODE_SEG_PC, holding the
// core in reset until the image is complete.
// Optional feature: define IM_LOADER_CHECKSUM_EN to require a trailing
// checksum word (sum mod 2^32 of the data words) before declaring done.
// Byte handshake: a byte transfers on a rising edge where byteValid and
// byteReady are both high; the source holds byteIn stable while it waits.
module im_loader
  import im_loader_pkg::*;
#(
  parameter logic [31:0] CODE_SEG_PC = CODE_SEG_PC_DEFAULT,
  parameter int          IM_WORDS    = IM_WORDS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 byteIn,
  input  logic                       byteValid,
  output logic                       byteReady,
  output logic                       imWe,
  output logic [31:0]                imAddr,
  output logic [31:0]                imData,
  output logic                       cpuReset,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(IM_WORDS):0]  wordCount,
  output state_e                     dbg_state
);

  localparam int CW = $clog2(IM_WORDS) + 1;

  state_e          state_q, state_d;
  logic [31:0]     len_q, len_d;
  logic [31:0]     word_q, word_d;
  logic [CW-1:0]   word_count_q, word_count_d;
  logic            asm_clear;
  logic            byte_fire;
  logic            word_valid;
  logic [31:0]     word;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]     sum_q, sum_d;
`endif

  assign byte_fire = byteValid && byteReady;

  im_loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_in    (byteIn),
    .byte_fire  (byte_fire),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state and datapath control for the load session.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    asm_clear    = 1'b0;
    imWe         = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d      = ST_LEN;
          word_count_d = '0;
          asm_clear    = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
          sum_d        = '0;
`endif
        end
      end
      ST_LEN: begin
        if (word_valid) begin
          len_d = word;
          if (word == 32'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else if (word > 32'(IM_WORDS)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          word_d  = word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        imWe         = 1'b1;
        word_count_d = word_count_q + CW'(1);
`ifdef IM_LOADER_CHECKSUM_EN
        sum_d        = sum_q + word_q;
`endif
        if (32'(word_count_d) == len_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (word_valid) begin
          state_d = (word == sum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_q       <= '0;
      word_count_q <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign byteReady = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign busy      = byteReady || (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);
  assign cpuReset  = (state_q != ST_DONE);
  assign imAddr    = CODE_SEG_PC + (32'(word_count_q) << 2);
  assign imData    = word_q;
  assign wordCount = word_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader: directed test-plan sessions plus randomized
// sessions, with IM writes checked by a scoreboard monitor.
module tb_im_loader;
  import im_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        imWe;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic        cpuReset;
  logic        busy;
  logic        done;
  logic        error;
  logic [10:0] wordCount;
  state_e      dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] exp_q[$];

  im_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .byteIn    (byteIn),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .imWe      (imWe),
    .imAddr    (imAddr),
    .imData    (imData),
    .cpuReset  (cpuReset),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .wordCount (wordCount),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (reset === 1'b0 && imWe === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {imAddr, imData}, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        e = exp_q.pop_front();
        check("im_write", {imAddr, imData}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit expect_we);
    int budget;
    if (gap > 0) begin
      byteValid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byteIn    = b;
    byteValid = 1'b1;
    budget    = 0;
    while (!byteReady && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!byteReady) begin
      check("byte_accept_timeout", 64'd0, 64'd1);
      byteValid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      if (expect_we) check("imwe_latency", {63'd0, imWe}, 64'd1);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit is_data, input bit gap3, input bit rand_gaps);
    logic [31:0] v;
    int g;
    v = w;
    for (int j = 0; j < 4; j++) begin
      g = 0;
      if (gap3 && j == 2) g = 3;
      else if (rand_gaps && $urandom_range(0, 3) == 0) g = int'($urandom_range(1, 2));
      send_byte(v[31:24], g, is_data && (j == 3));
      v = v << 8;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_to_len", {62'd0, busy, byteReady}, 64'd3);
  endtask

  // Reference model: writes go to CODE_SEG_PC + 4*i in stream order; the
  // session fails if N exceeds capacity or (checksum build) the checksum
  // differs from the 32-bit sum of the words.
  task automatic run_session(input logic [31:0] n, input logic [31:0] words[$],
                             input logic [31:0] csum, input bit gap3, input bit rand_gaps);
    bit          len_err;
    bit          exp_done;
    logic [31:0] sum;
    logic [10:0] exp_wc;
    len_err  = (n > 32'(IM_WORDS_DEFAULT));
    sum      = 32'd0;
    foreach (words[i]) sum = sum + words[i];
    exp_done = !len_err;
`ifdef IM_LOADER_CHECKSUM_EN
    if (!len_err) exp_done = (csum == sum);
`endif
    exp_wc = len_err ? 11'd0 : n[10:0];

    pulse_start();
    send_word(n, 1'b0, 1'b0, rand_gaps);
    if (!len_err) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back({CODE_SEG_PC_DEFAULT + 32'(i) * 32'd4, words[i]});
        send_word(words[i], 1'b1, gap3, rand_gaps);
      end
`ifdef IM_LOADER_CHECKSUM_EN
      send_word(csum, 1'b0, 1'b0, rand_gaps);
`endif
    end
    byteValid = 1'b0;
    for (int i = 0; i < 20 && !(done || error); i++) @(negedge clk);
    check("session_status", {60'd0, done, error, cpuReset, busy},
          {60'd0, exp_done, !exp_done, !exp_done, 1'b0});
    check("session_word_count", {53'd0, wordCount}, {53'd0, exp_wc});
    check("session_writes_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_ctl"}, {58'd0, byteReady, imWe, cpuReset, busy, done, error}, 64'b001000);
    check({name, "_addr"}, {32'd0, imAddr}, {32'd0, CODE_SEG_PC_DEFAULT});
    check({name, "_data_count"}, {21'd0, wordCount, imData}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w[$];
    logic [31:0] s;
    int          n;
    reset     = 1'b1;
    start     = 1'b0;
    byteValid = 1'b0;
    byteIn    = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_values("idle_after_reset");

    // Two-word image, continuous valid.
    w = '{32'h2408_0005, 32'h8C09_0004};
    run_session(32'd2, w, 32'hB011_0009, 1'b0, 1'b0);

    // Over-capacity length, then a good one-word image.
    w = '{};
    run_session(32'h0000_0401, w, 32'd0, 1'b0, 1'b0);
    w = '{32'h1234_5678};
    run_session(32'd1, w, 32'h1234_5678, 1'b0, 1'b0);

    // Valid gap between bytes 2 and 3, bytes offered during WRITE.
    w = '{32'h2408_0005, 32'h8C09_0004};
    run_session(32'd2, w, 32'hB011_0009, 1'b1, 1'b0);

    // Empty image.
    w = '{};
    run_session(32'd0, w, 32'd0, 1'b0, 1'b0);

    // Reset after 1 of 3 words written.
    pulse_start();
    send_word(32'd3, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({CODE_SEG_PC_DEFAULT, 32'hAAAA_5555});
    send_word(32'hAAAA_5555, 1'b1, 1'b0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    reset     = 1'b1;
    byteValid = 1'b0;
    @(negedge clk);
    check_reset_values("mid_session_reset");
    check("mid_reset_writes_drained", 64'(exp_q.size()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    w = '{32'hCAFE_F00D};
    run_session(32'd1, w, 32'hCAFE_F00D, 1'b0, 1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
    w = '{32'h0000_0001, 32'hFFFF_FFFF};
    run_session(32'd2, w, 32'h0000_0000, 1'b0, 1'b0);
    run_session(32'd2, w, 32'h0000_0001, 1'b0, 1'b0);
`endif

    // Randomized sessions.
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(0, 6));
      w = '{};
      s = 32'd0;
      for (int i = 0; i < n; i++) begin
        w.push_back($urandom);
        s = s + w[i];
      end
      if ($urandom_range(0, 3) == 0) s = s + 32'd1;
      run_session(32'(n), w, s, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
